// File: rtl/tone_gen.sv
// Waveform and envelope sample source feeding the PWM DAC duty value.
// Optional build macro TONE_GEN_ENVELOPE_EN enables the ADSR-style envelope FSM and output multiplier.
module tone_gen #(
    parameter int unsigned N     = 8,
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sample_req,
    input  logic [ACC_W-1:0] freq_word,
    input  logic [1:0]       wave_sel,
    input  logic             gate,
    input  logic [7:0]       att_step,
    input  logic [7:0]       rel_step,
    output logic [N-1:0]     sample,
    output logic             sample_valid,
    output logic [1:0]       env_state
);

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned ENV_W  = 8;
    localparam int unsigned PROD_W = N + ENV_W;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_e;

    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [LFSR_W-1:0] lfsr, lfsr_nxt;
    env_state_e        state, state_nxt;
    logic [N-1:0]      sample_nxt;
    logic              valid_nxt;
    logic              accept;
    logic [N-1:0]      p;
    logic [N-1:0]      noise;
    logic [N-1:0]      w;
    logic              lfsr_fb;

    // Raw waveform from the pre-update phase and LFSR
    always_comb begin
        accept  = sample_req && ena;
        p       = acc[ACC_W-1 -: N];
        noise   = lfsr[LFSR_W-1 -: N];
        lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        w       = '0;
        case (wave_sel)
            2'd0:    w = p[N-1] ? '1 : '0;
            2'd1:    w = p;
            2'd2:    w = p[N-1] ? ~{p[N-2:0], 1'b0} : {p[N-2:0], 1'b0};
            2'd3:    w = noise;
            default: w = '0;
        endcase
    end

    // Phase and noise advance once per accepted request
    always_comb begin
        acc_nxt   = acc;
        lfsr_nxt  = lfsr;
        valid_nxt = accept;
        if (accept) begin
            acc_nxt  = acc + freq_word;
            lfsr_nxt = {lfsr[LFSR_W-2:0], lfsr_fb};
        end
    end

`ifdef TONE_GEN_ENVELOPE_EN
    logic [ENV_W-1:0]  env, env_nxt;
    logic [ENV_W:0]    att_sum;
    logic [PROD_W-1:0] prod;

    // Envelope FSM and scaled output
    always_comb begin
        att_sum    = {1'b0, env} + {1'b0, att_step};
        prod       = PROD_W'(w) * PROD_W'(env);
        env_nxt    = env;
        state_nxt  = state;
        sample_nxt = sample;
        if (accept) begin
            sample_nxt = N'(prod >> ENV_W);
            case (state)
                ST_IDLE: begin
                    if (gate) state_nxt = ST_ATTACK;
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        state_nxt = ST_RELEASE;
                    end else if (att_step == 8'd0 || att_sum >= 9'd255) begin
                        env_nxt   = 8'hFF;
                        state_nxt = ST_SUSTAIN;
                    end else begin
                        env_nxt = att_sum[ENV_W-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    env_nxt = 8'hFF;
                    if (!gate) state_nxt = ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Retrigger keeps the current level rather than restarting from zero
                    if (gate) begin
                        state_nxt = ST_ATTACK;
                    end else if (rel_step == 8'd0 || env <= rel_step) begin
                        env_nxt   = 8'd0;
                        state_nxt = ST_IDLE;
                    end else begin
                        env_nxt = env - rel_step;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env <= '0;
        end else begin
            env <= env_nxt;
        end
    end
`else
    logic unused_steps;

    // Gate-only output; status mirrors the gate as SUSTAIN/IDLE
    always_comb begin
        unused_steps = ^{att_step, rel_step};
        state_nxt    = state;
        sample_nxt   = sample;
        if (accept) begin
            sample_nxt = gate ? w : '0;
            state_nxt  = gate ? ST_SUSTAIN : ST_IDLE;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            lfsr         <= LFSR_SEED;
            state        <= ST_IDLE;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            acc          <= acc_nxt;
            lfsr         <= lfsr_nxt;
            state        <= state_nxt;
            sample       <= sample_nxt;
            sample_valid <= valid_nxt;
        end
    end

    assign env_state = state;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen (N=8, ACC_W=16); covers both TONE_GEN_ENVELOPE_EN builds.
module tb_tone_gen;

    localparam int unsigned N     = 8;
    localparam int unsigned ACC_W = 16;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             ena        = 1'b1;
    logic             sample_req = 1'b0;
    logic [ACC_W-1:0] freq_word  = '0;
    logic [1:0]       wave_sel   = 2'd0;
    logic             gate       = 1'b0;
    logic [7:0]       att_step   = 8'd0;
    logic [7:0]       rel_step   = 8'd0;
    logic [N-1:0]     sample;
    logic             sample_valid;
    logic [1:0]       env_state;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    tone_gen #(.N(N), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .sample_req   (sample_req),
        .freq_word    (freq_word),
        .wave_sel     (wave_sel),
        .gate         (gate),
        .att_step     (att_step),
        .rel_step     (rel_step),
        .sample       (sample),
        .sample_valid (sample_valid),
        .env_state    (env_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One accepted request, then check the registered result on the following negedge
    task automatic req_chk(input string tag, input logic [7:0] exp_s, input logic [1:0] exp_st);
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        chk({tag, ".sample"}, 32'(sample), 32'(exp_s));
        chk({tag, ".valid"}, 32'(sample_valid), 32'd1);
        chk({tag, ".state"}, 32'(env_state), 32'(exp_st));
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, ".valid_low"}, 32'(sample_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.sample", 32'(sample), 32'd0);
        chk("rst.valid", 32'(sample_valid), 32'd0);
        chk("rst.state", 32'(env_state), 32'd0);
        rst_n = 1'b1;

`ifdef TONE_GEN_ENVELOPE_EN
        gate = 1'b1; att_step = 8'd64; rel_step = 8'd100;
        wave_sel = 2'd0; freq_word = 16'h8000;
        req_chk("e1", 8'h00, 2'd1);
        freq_word = 16'h0000;
        req_chk("e2", 8'h00, 2'd1);
        req_chk("e3", 8'h3F, 2'd1);
        req_chk("e4", 8'h7F, 2'd1);
        req_chk("e5", 8'hBF, 2'd2);
        req_chk("e6", 8'hFE, 2'd2);
        idle_chk("e6");
        gate = 1'b0;
        req_chk("e7", 8'hFE, 2'd3);
        req_chk("e8", 8'hFE, 2'd3);
        req_chk("e9", 8'h9A, 2'd3);
        req_chk("e10", 8'h36, 2'd0);
        req_chk("e11", 8'h00, 2'd0);
        gate = 1'b1;
        req_chk("r1", 8'h00, 2'd1);
        req_chk("r2", 8'h00, 2'd1);
        req_chk("r3", 8'h3F, 2'd1);
        gate = 1'b0;
        req_chk("r4", 8'h7F, 2'd3);
        req_chk("r5", 8'h7F, 2'd3);
        gate = 1'b1;
        req_chk("r6", 8'h1B, 2'd1);
        req_chk("r7", 8'h1B, 2'd1);
        req_chk("r8", 8'h5B, 2'd1);
        att_step = 8'd0;
        req_chk("r9", 8'h9B, 2'd2);
        req_chk("r10", 8'hFE, 2'd2);
        // Dropped request must not touch the envelope
        @(negedge clk);
        ena = 1'b0; sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0; ena = 1'b1;
        chk("drop.valid", 32'(sample_valid), 32'd0);
        chk("drop.state", 32'(env_state), 32'd2);
        req_chk("r11", 8'hFE, 2'd2);
`else
        gate = 1'b1; freq_word = 16'h1000;
        wave_sel = 2'd3; req_chk("n1", 8'hAC, 2'd2);
        idle_chk("n1");
        req_chk("n2", 8'h59, 2'd2);
        wave_sel = 2'd1; req_chk("saw1", 8'h20, 2'd2);
        wave_sel = 2'd2; req_chk("tri1", 8'h60, 2'd2);
        freq_word = 16'h4000;
        wave_sel = 2'd0; req_chk("sq_lo", 8'h00, 2'd2);
        req_chk("sq_hi", 8'hFF, 2'd2);
        freq_word = 16'h5000;
        wave_sel = 2'd2; req_chk("tri_hi", 8'h7F, 2'd2);
        wave_sel = 2'd1; req_chk("saw_wrap", 8'h10, 2'd2);
        gate = 1'b0;
        req_chk("gate_off", 8'h00, 2'd0);
        // ena dropped while sample_req is high: no update
        @(negedge clk);
        ena = 1'b0; sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0; ena = 1'b1;
        chk("drop.valid", 32'(sample_valid), 32'd0);
        chk("drop.sample", 32'(sample), 32'd0);
        gate = 1'b1; freq_word = 16'h1000;
        wave_sel = 2'd3; req_chk("n_held", 8'hC3, 2'd2);
        wave_sel = 2'd1; req_chk("acc_held", 8'hC0, 2'd2);
        // Back-to-back requests
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        chk("b2b1.sample", 32'(sample), 32'hD0);
        chk("b2b1.valid", 32'(sample_valid), 32'd1);
        @(negedge clk);
        sample_req = 1'b0;
        chk("b2b2.sample", 32'(sample), 32'hE0);
        chk("b2b2.valid", 32'(sample_valid), 32'd1);
        idle_chk("b2b");
        // Asynchronous reset while a result is pending
        req_chk("pre_rst", 8'hF0, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.sample", 32'(sample), 32'd0);
        chk("arst.valid", 32'(sample_valid), 32'd0);
        chk("arst.state", 32'(env_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wave_sel = 2'd3; req_chk("n_seed", 8'hAC, 2'd2);
        wave_sel = 2'd1; req_chk("saw_rst", 8'h10, 2'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
# tone_gen

Waveform-and-envelope sample source for the sound generator, sitting directly upstream of the PWM DAC. On each sample request from the DAC (one pulse per PWM period) it advances a phase accumulator and a noise LFSR, steps an attack/sustain/release envelope, and presents a new N-bit unsigned sample that the DAC uses as its duty value (`t_on`). All datapath state is local; the top level only wires switches and the gate to it.

## Interface
- `N`, 8: sample width in bits, 2..16.
- `ACC_W`, 16: phase accumulator width, ≥ N.
- `clk` input 1: clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: block enable; when low, `sample_req` is ignored and all state holds.
- `sample_req` input 1: one-cycle pulse from DAC at PWM period end.
- `freq_word` input ACC_W: phase increment per sample.
- `wave_sel` input 2: 0 square, 1 saw, 2 triangle, 3 noise.
- `gate` input 1: note on (high) / off (low).
- `att_step` input 8: envelope increment per sample in ATTACK; 0 means instant.
- `rel_step` input 8: envelope decrement per sample in RELEASE; 0 means instant.
- `sample` output N: current sample for the DAC.
- `sample_valid` output 1: one-cycle pulse, `sample` updated this cycle.
- `env_state` output 2: 0 IDLE, 1 ATTACK, 2 SUSTAIN, 3 RELEASE (debug/status).

## Operation
- Reset values: `acc`=0, `lfsr`=16'hACE1, `env`=0, state IDLE, `sample`=0, `sample_valid`=0, `env_state`=0.
- An accepted request is `sample_req && ena`. Everything below happens only on accepted requests; other cycles hold.
- Phase: `acc <= acc + freq_word`, modulo 2^ACC_W (wrap silently). `p` = `acc[ACC_W-1 -: N]` (pre-update value).
- LFSR: Fibonacci, shift left, new bit0 = l[15]^l[13]^l[12]^l[10]; noise value = `lfsr[15 -: N]` (pre-update value).
- Raw wave `w`: square = all ones if p[N-1] else 0; saw = p; triangle = p[N-1] ? ~{p[N-2:0],0} : {p[N-2:0],0}; noise as above.
- Envelope FSM (evaluated from pre-update `gate`/state/`env`):
  - IDLE: gate=1 → ATTACK; env stays 0.
  - ATTACK: gate=0 → RELEASE (env unchanged this request). Otherwise env ← min(env+att_step, 255), or 255 if att_step=0; reaching 255 → SUSTAIN in the same update.
  - SUSTAIN: env=255; gate=0 → RELEASE.
  - RELEASE: gate=1 → ATTACK (retrigger from current env, no reset to 0). Otherwise env ← max(env−rel_step, 0), or 0 if rel_step=0; reaching 0 → IDLE in the same update.
- Output: `sample <= (w * env) >> 8`, keeping the low N bits of the (N+8)-bit product shifted right by 8, using the pre-update env. At env=255 and w=all ones, sample = w − 1.
- `gate` changes between requests are seen only at the next accepted request.

## Timing
- Latency: accepted request in cycle t → `sample`, `sample_valid`=1, acc, lfsr, env, and state all updated at the edge ending cycle t, visible in t+1. `sample_valid` drops in t+2 unless another request is accepted.
- Back-to-back requests (every cycle) are legal; each produces one update.
- `ena` falling while `sample_req` is high: request is dropped, no `sample_valid`.
- `rst_n` asserted mid-operation clears all state immediately (asynchronously), including a pending `sample_valid`.
- No combinational path from any input to any output.

## Configuration
- `TONE_GEN_ENVELOPE_EN` defined: envelope FSM and multiplier as above.
- Not defined: no FSM and no multiplier. `sample <= gate ? w : 0` on each accepted request. `env_state` reads 2 (SUSTAIN) while gate=1 and 0 (IDLE) otherwise. att_step/rel_step are unused.

## Test plan
- Reset: hold rst_n low mid-run → sample=0, sample_valid=0, env_state=0, next noise sample from lfsr 16'hACE1 (sample=0xAC for N=8 at full env).
- Saw, N=8, ACC_W=16, freq_word=0x1000, gate=1, att_step=0 → env 255 after first request; successive samples track p=0x10,0x20,… scaled by 255>>8; wrap after 16 requests to p=0.
- Envelope: att_step=64, gate=1, square → env 64,128,192,255 then SUSTAIN; gate low, rel_step=100 → 155,55,0 then IDLE.
- Retrigger: gate drop at env=128 then raise on the next request → RELEASE for one step, then ATTACK from the decremented value, not from 0.
- ena low with sample_req pulses → no sample_valid, acc/lfsr/env unchanged; re-enable → continues from the held values.
- Macro undefined: gate=1, saw → sample equals p exactly; gate=0 → sample=0 on the next request.
